// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//   Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges
//   load-use hazard detection, taken-branch flushing and a multi-cycle
//   mult/div occupancy FSM into one set of PC, IF/ID and ID/EX strobes.
//
// Parameters
//   MULDIV_CYCLES  cycles a mult/div occupies EX (2..15)
//   CNT_W          width of the mult/div cycle counter
//   PERF_W         width of the StallCount performance counter
//
// Ports
//   Clk, Reset            clock, synchronous active-high reset
//   rsDecode, rtDecode    source fields of the instruction in ID
//   UsesRtDecode          ID instruction reads rt
//   rtExecution           destination of the instruction in EX
//   MemReadExecution      EX instruction is a load
//   MulDivDecode          ID instruction is mult/multu/div/divu
//   BranchTakenExecution  branch/jump in EX resolved taken
//   PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble
//                         pipeline register control strobes
//   MulDivStart           one-cycle issue pulse for mult/div
//   MulDivBusy            mult/div is holding EX
//   StallCount            saturating count of cycles with PCWrite==0
// ---------------------------------------------------------------------------
module pipeline_stall_controller #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 4,
  parameter int PERF_W        = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [4:0]        rsDecode,
  input  logic [4:0]        rtDecode,
  input  logic              UsesRtDecode,
  input  logic [4:0]        rtExecution,
  input  logic              MemReadExecution,
  input  logic              MulDivDecode,
  input  logic              BranchTakenExecution,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              IFIDFlush,
  output logic              IDEXWrite,
  output logic              IDEXBubble,
  output logic              MulDivStart,
  output logic              MulDivBusy,
  output logic [PERF_W-1:0] StallCount
);

  typedef enum logic [1:0] {
    S_RUN    = 2'b00,
    S_MULDIV = 2'b01
  } state_t;

  // The issue cycle itself is one of the EX cycles, so the counter covers
  // the remaining MULDIV_CYCLES-1 busy cycles.
  localparam logic [CNT_W-1:0]  LP_CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [PERF_W-1:0] LP_PERF_MAX = '1;

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_next_cnt;
  logic [PERF_W-1:0] r_stall_count;
  logic              w_load_use;

  // rt==$zero never creates a real dependency.
  assign w_load_use = MemReadExecution && (rtExecution != 5'd0) &&
                      ((rsDecode == rtExecution) ||
                       (UsesRtDecode && (rtDecode == rtExecution)));

  always_comb begin
    // NOTE: every output and next-state signal gets a default first, so no
    // path through the case statement can infer a latch.
    PCWrite      = 1'b1;
    IFIDWrite    = 1'b1;
    IFIDFlush    = 1'b0;
    IDEXWrite    = 1'b1;
    IDEXBubble   = 1'b0;
    MulDivStart  = 1'b0;
    MulDivBusy   = 1'b0;
    w_next_state = r_state;
    w_next_cnt   = r_cnt;

    if (Reset) begin
      // Outputs stay at the free-running defaults while in reset.
      w_next_state = S_RUN;
      w_next_cnt   = '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (BranchTakenExecution) begin
            // Younger instructions are on the wrong path; kill them and
            // let the PC load the target.
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
          end else if (w_load_use) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
          end else if (MulDivDecode) begin
            MulDivStart  = 1'b1;
            w_next_cnt   = LP_CNT_LOAD;
            w_next_state = S_MULDIV;
          end
        end
        S_MULDIV: begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXWrite  = 1'b0;
          MulDivBusy = 1'b1;
          w_next_cnt = r_cnt - CNT_W'(1);
          // <= rather than == also rescues a counter that somehow reads 0.
          if (r_cnt <= CNT_W'(1)) begin
            w_next_state = S_RUN;
          end
        end
        default: begin
          w_next_state = S_RUN;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (Reset) begin
      r_state       <= S_RUN;
      r_cnt         <= '0;
      r_stall_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (!PCWrite && (r_stall_count != LP_PERF_MAX)) begin
        r_stall_count <= r_stall_count + PERF_W'(1);
      end
    end
  end

  assign StallCount = r_stall_count;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_controller
//   Directed bench for pipeline_stall_controller (MULDIV_CYCLES=4, PERF_W=4).
//   A cycle-level reference model tracks "busy cycles remaining" and the
//   stall total; a compare process checks every output on each falling edge.
//   Literal expectations in the stimulus pin the model to known answers.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_controller;

  localparam int MD     = 4;
  localparam int PERF_W = 4;
  localparam int PMAX   = (1 << PERF_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [4:0]        rs_d, rt_d, rt_e;
  logic              uses_rt, mem_e, md_d, br_e;
  logic              pc_w, ifid_w, ifid_f, idex_w, idex_b, md_start, md_busy;
  logic [PERF_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_stall_controller #(
    .MULDIV_CYCLES(MD),
    .CNT_W        (4),
    .PERF_W       (PERF_W)
  ) dut (
    .Clk                 (clk),
    .Reset               (rst),
    .rsDecode            (rs_d),
    .rtDecode            (rt_d),
    .UsesRtDecode        (uses_rt),
    .rtExecution         (rt_e),
    .MemReadExecution    (mem_e),
    .MulDivDecode        (md_d),
    .BranchTakenExecution(br_e),
    .PCWrite             (pc_w),
    .IFIDWrite           (ifid_w),
    .IFIDFlush           (ifid_f),
    .IDEXWrite           (idex_w),
    .IDEXBubble          (idex_b),
    .MulDivStart         (md_start),
    .MulDivBusy          (md_busy),
    .StallCount          (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int   m_busy_left = 0;   // busy cycles still owed by an issued mult/div
  int   m_stall     = 0;
  logic e_pc    = 1'b1;
  logic e_start = 1'b0;

  always @(negedge clk) begin
    logic lu;
    logic pc, ifw, fl, idw, bb, st, bz;
    lu  = mem_e && (rt_e != 0) && ((rs_d == rt_e) || (uses_rt && (rt_d == rt_e)));
    pc  = 1; ifw = 1; fl = 0; idw = 1; bb = 0; st = 0; bz = 0;
    if (!rst) begin
      if (m_busy_left > 0) begin
        pc = 0; ifw = 0; idw = 0; bz = 1;
      end else if (br_e) begin
        fl = 1; bb = 1;
      end else if (lu) begin
        pc = 0; ifw = 0; bb = 1;
      end else if (md_d) begin
        st = 1;
      end
    end
    check("PCWrite",     pc_w,     pc);
    check("IFIDWrite",   ifid_w,   ifw);
    check("IFIDFlush",   ifid_f,   fl);
    check("IDEXWrite",   idex_w,   idw);
    check("IDEXBubble",  idex_b,   bb);
    check("MulDivStart", md_start, st);
    check("MulDivBusy",  md_busy,  bz);
    check("StallCount",  stall_cnt, m_stall);
    e_pc    = pc;
    e_start = st;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_busy_left = 0;
      m_stall     = 0;
    end else begin
      if (!e_pc && m_stall < PMAX) m_stall++;
      if (m_busy_left > 0)  m_busy_left--;
      else if (e_start)     m_busy_left = MD - 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_d = 5'd1; rt_d = 5'd2; rt_e = 5'd3;
    uses_rt = 1'b0; mem_e = 1'b0; md_d = 1'b0; br_e = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    rst  = 1'b1;
    md_d = 1'b1;
    br_e = 1'b1;
    step();
    step();
    settle();
    check("rst PCWrite",     pc_w,      1);
    check("rst IDEXWrite",   idex_w,    1);
    check("rst MulDivStart", md_start,  0);
    check("rst IFIDFlush",   ifid_f,    0);
    check("rst StallCount",  stall_cnt, 0);

    // Load-use on rs: exactly one bubble.
    step(); rst = 1'b0; idle();
    mem_e = 1'b1; rt_e = 5'd8; rs_d = 5'd8;
    settle();
    check("lu PCWrite",    pc_w,   0);
    check("lu IFIDWrite",  ifid_w, 0);
    check("lu IDEXBubble", idex_b, 1);
    step(); idle(); settle();
    check("lu after PCWrite", pc_w,      1);
    check("lu StallCount",    stall_cnt, 1);

    // rt==$zero and rt-only match without UsesRt: no stall; with UsesRt: stall.
    step(); mem_e = 1'b1; rt_e = 5'd0; rs_d = 5'd0; settle();
    check("zero reg PCWrite", pc_w, 1);
    step(); rt_e = 5'd9; rt_d = 5'd9; rs_d = 5'd3; uses_rt = 1'b0; settle();
    check("rt no-use PCWrite", pc_w, 1);
    step(); uses_rt = 1'b1; settle();
    check("rt use PCWrite", pc_w, 0);
    step(); idle(); settle();
    check("rt use StallCount", stall_cnt, 2);

    // Single mult/div: start, 3 busy cycles (branch/hazard ignored), RUN.
    step(); md_d = 1'b1; settle();
    check("md start",   md_start, 1);
    check("md start PC", pc_w,    1);
    step(); md_d = 1'b0; settle();
    check("md busy1",      md_busy, 1);
    check("md busy1 IDEX", idex_w,  0);
    step(); br_e = 1'b1; mem_e = 1'b1; rt_e = 5'd8; rs_d = 5'd8; settle();
    check("md busy2",       md_busy, 1);
    check("md busy2 flush", ifid_f,  0);
    step(); idle(); settle();
    check("md busy3", md_busy, 1);
    step(); settle();
    check("md done busy",  md_busy,   0);
    check("md done PC",    pc_w,      1);
    check("md StallCount", stall_cnt, 5);

    // Back-to-back mult/div with no idle gap.
    step(); md_d = 1'b1; settle();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        step(); settle();
      end
      check("b2b start", md_start, (i % MD) == 0);
      check("b2b busy",  md_busy,  (i % MD) != 0);
    end
    step(); md_d = 1'b0; settle();
    check("b2b done busy",  md_busy,   0);
    check("b2b StallCount", stall_cnt, 11);

    // Branch beats load-use and mult/div.
    step(); br_e = 1'b1; mem_e = 1'b1; rt_e = 5'd8; rs_d = 5'd8; md_d = 1'b1; settle();
    check("br flush",  ifid_f,   1);
    check("br bubble", idex_b,   1);
    check("br PC",     pc_w,     1);
    check("br start",  md_start, 0);
    step(); idle(); settle();
    check("br stays RUN", md_busy,   0);
    check("br StallCount", stall_cnt, 11);

    // Reset in the 2nd MULDIV cycle.
    step(); md_d = 1'b1; settle();
    check("rmd start", md_start, 1);
    step(); md_d = 1'b0; settle();
    check("rmd busy1", md_busy, 1);
    step(); rst = 1'b1; settle();
    check("rmd rst PC",     pc_w,      1);
    check("rmd rst busy",   md_busy,   0);
    check("rmd rst IDEX",   idex_w,    1);
    check("rmd rst count",  stall_cnt, 12);
    step(); rst = 1'b0; settle();
    check("rmd after busy",  md_busy,   0);
    check("rmd after PC",    pc_w,      1);
    check("rmd after count", stall_cnt, 0);

    // 20 consecutive stalls saturate a 4-bit counter at 15.
    step(); mem_e = 1'b1; rt_e = 5'd8; rs_d = 5'd8; settle();
    for (int i = 1; i < 20; i++) step();
    step(); idle(); settle();
    check("sat count", stall_cnt, PMAX);
    step(); mem_e = 1'b1; rt_e = 5'd8; rs_d = 5'd8; settle();
    step(); idle(); settle();
    check("sat hold", stall_cnt, PMAX);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
